// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 serializer: accepts one scan-code byte over valid/ready and
// drives the 11-bit device-to-host frame (start, 8 data LSB first, odd parity, stop).
module ps2_kbd_tx #(
  parameter int unsigned HALF_PERIOD = 2000,
  parameter int unsigned GAP_CYCLES  = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  // Handshake: a byte transfers on a rising clk edge where tx_valid and
  // tx_ready are both high; tx_valid without tx_ready is simply ignored.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_BIT = 4'd10;

  state_e      state_q,    state_d;
  logic [10:0] shift_q,    shift_d;
  logic [3:0]  bit_idx_q,  bit_idx_d;
  logic [15:0] hp_cnt_q,   hp_cnt_d;
  logic [15:0] gap_cnt_q,  gap_cnt_d;
  logic        ps2_clk_q,  ps2_clk_d;
  logic        ps2_data_q, ps2_data_d;
  logic        busy_q,     busy_d;
  logic        accept;

  // rst is folded in so nothing can be accepted on a reset cycle.
  assign tx_ready = (state_q == IDLE) && !inhibit && !rst;
  assign accept   = tx_valid && tx_ready;

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;
  assign busy     = busy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    hp_cnt_d   = hp_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // shift_q[0] is always the bit currently on the wire.
          shift_d    = {1'b1, ~^tx_data, tx_data, 1'b0};
          ps2_data_d = 1'b0;
          ps2_clk_d  = 1'b1;
          busy_d     = 1'b1;
          bit_idx_d  = 4'd0;
          hp_cnt_d   = 16'd0;
          state_d    = BIT_HI;
        end
      end

      BIT_HI: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d  = 16'd0;
          ps2_clk_d = 1'b0;
          state_d   = BIT_LO;
        end else begin
          hp_cnt_d = hp_cnt_q + 16'd1;
        end
      end

      BIT_LO: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d  = 16'd0;
          ps2_clk_d = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            gap_cnt_d  = 16'd0;
            ps2_data_d = 1'b1;
            state_d    = GAP;
          end else begin
            // Data moves only together with the rising ps2_clk.
            bit_idx_d  = bit_idx_q + 4'd1;
            shift_d    = {1'b1, shift_q[10:1]};
            ps2_data_d = shift_q[1];
            state_d    = BIT_HI;
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 16'd1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 16'd0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      hp_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      hp_cnt_q   <= hp_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: cycle-level waveform model, bus decoder with an
// expected-byte queue, directed scenarios followed by randomized traffic.
module tb_ps2_kbd_tx;

  localparam int HP      = 4;
  localparam int GP      = 8;
  localparam int FRAME   = 22 * HP;
  localparam int PERIOD  = FRAME + GP + 1;
  localparam int TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  ps2_kbd_tx #(
    .HALF_PERIOD(HP),
    .GAP_CYCLES (GP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .inhibit (inhibit),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // One frame = a byte plus a cycle offset m_k since acceptance (1-based).
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [7:0] exp_q[$];

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return (ones % 2 == 0);
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_k      = 0;
      exp_q.delete();
    end else if (m_active) begin
      m_k++;
      if (m_k > FRAME + GP) begin
        m_active = 1'b0;
        m_k      = 0;
      end
    end else if (tx_valid && !inhibit) begin
      m_active = 1'b1;
      m_k      = 1;
      m_byte   = tx_data;
      exp_q.push_back(tx_data);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_clk    = 1'b1;
  logic        prev_data   = 1'b1;
  int          n_bits      = 0;
  logic [10:0] bits        = '0;
  logic [10:0] frame_log[$];
  int          first_fall_k = -1;

  initial forever begin
    logic       e_clk, e_data, e_busy, e_ready;
    logic [7:0] e_byte;
    int         h, ones;
    @(negedge clk);
    if (cyc >= 1) begin
      if (m_active && m_k <= FRAME) begin
        h      = (m_k - 1) / HP;
        e_clk  = (h % 2 == 0);
        e_data = frame_bit(m_byte, h / 2);
        e_busy = 1'b1;
      end else if (m_active) begin
        e_clk  = 1'b1;
        e_data = 1'b1;
        e_busy = 1'b1;
      end else begin
        e_clk  = 1'b1;
        e_data = 1'b1;
        e_busy = 1'b0;
      end
      e_ready = !m_active && !inhibit && !rst;
      check("ps2_clk", ps2_clk, e_clk);
      check("ps2_data", ps2_data, e_data);
      check("busy", busy, e_busy);
      check("tx_ready", tx_ready, e_ready);
      if (!ps2_clk && !prev_clk) check("data_stable_low", ps2_data, prev_data);

      if (prev_clk && !ps2_clk) begin
        if (n_bits == 0) first_fall_k = m_k;
        bits[4'(n_bits)] = ps2_data;
        n_bits++;
        if (n_bits == 11) begin
          check("start_bit", bits[0], 1'b0);
          check("stop_bit", bits[10], 1'b1);
          ones = 0;
          for (int i = 1; i <= 9; i++) ones += int'(bits[i]);
          check("odd_parity", ones % 2, 1);
          frame_log.push_back(bits);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got data %0h expected no frame (cycle %0d)", bits[8:1], cyc);
          end else begin
            e_byte = exp_q.pop_front();
            check("frame_data", bits[8:1], e_byte);
          end
          n_bits = 0;
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
      if (rst) n_bits = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold, output int t_acc);
    int  waited;
    bit  hs;
    waited   = 0;
    t_acc    = -1;
    tx_data  = b;
    tx_valid = 1'b1;
    while (waited < TIMEOUT) begin
      @(negedge clk);
      hs = tx_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        t_acc = cyc;
        break;
      end
      waited++;
    end
    if (!hold) tx_valid = 1'b0;
    n_cmp++;
    if (t_acc < 0) begin
      n_err++;
      $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", b, TIMEOUT);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (w < TIMEOUT) begin
      @(negedge clk);
      if (!busy) break;
      w++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (w >= TIMEOUT) begin
      n_err++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, TIMEOUT);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         t0, t1, c_rel, n0;
    logic [7:0] b;
    bit         hold;

    rst      = 1'b1;
    tx_valid = 1'b0;
    inhibit  = 1'b0;
    tx_data  = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single byte with known bit pattern and timing.
    send_byte(8'h1C, 1'b0, t0);
    wait_idle();
    check("bits_1C", frame_log.size() > 0 ? frame_log[frame_log.size()-1] : 11'h7FF, 11'b10000111000);
    check("first_fall_offset", first_fall_k, 5);

    // Back-to-back frames with tx_valid held.
    n0 = frame_log.size();
    send_byte(8'h00, 1'b1, t0);
    tx_data = 8'hFF;
    send_byte(8'hFF, 1'b0, t1);
    check("b2b_spacing", t1 - t0, PERIOD);
    wait_idle();
    check("b2b_frames", frame_log.size() - n0, 2);
    if (frame_log.size() - n0 == 2) begin
      check("parity_00", frame_log[n0][9], 1'b1);
      check("parity_FF", frame_log[n0+1][9], 1'b1);
    end

    // Inhibit in IDLE blocks acceptance; release accepts on next edge.
    inhibit  = 1'b1;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    repeat (40) step();
    inhibit = 1'b0;
    c_rel   = cyc;
    send_byte(8'h5A, 1'b0, t0);
    check("accept_after_release", t0 - c_rel, 1);
    wait_idle();

    // Inhibit raised mid-frame does not disturb the frame.
    send_byte(8'h3C, 1'b0, t0);
    repeat (29) step();
    inhibit = 1'b1;
    wait_idle();
    repeat (5) step();
    inhibit = 1'b0;
    step();

    // Reset in the middle of the data bits.
    send_byte(8'h96, 1'b0, t0);
    repeat (39) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("busy_after_rst", busy, 1'b0);
    check("ps2_clk_after_rst", ps2_clk, 1'b1);
    check("ps2_data_after_rst", ps2_data, 1'b1);
    send_byte(8'h2B, 1'b0, t1);
    wait_idle();

    // tx_valid pulse while busy is ignored.
    send_byte(8'h47, 1'b0, t0);
    n0 = frame_log.size();
    repeat (9) step();
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    wait_idle();
    repeat (3) step();
    check("busy_pulse_frames", frame_log.size() - n0, 1);

    // Randomized traffic with inhibit pulses and occasional resets.
    for (int it = 0; it < 30; it++) begin
      b    = 8'($urandom_range(0, 255));
      hold = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) step();
      if ($urandom_range(0, 3) == 0) begin
        inhibit = 1'b1;
        repeat ($urandom_range(1, 6)) step();
        inhibit = 1'b0;
      end
      send_byte(b, hold, t0);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 90)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (5) step();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
